// File: rtl/fetch_queue.sv
// Instruction fetch queue: accepts one 64-bit fetch word (two instructions, older
// half optionally skipped) per cycle and presents the two oldest to dual-issue decode.
module fetch_queue #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          in_valid,
  input  logic          in_skip0,
  input  logic [63:0]   in_data,
  output logic          in_ready,
  output logic          out_valid0,
  output logic [31:0]   out_inst0,
  output logic          out_valid1,
  output logic [31:0]   out_inst1,
  input  logic [1:0]    issue,
  output logic [AW:0]   count
);

  localparam logic [AW:0] READY_MAX = (AW+1)'(DEPTH - 2);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [AW-1:0] headNext;
  logic [AW-1:0] tailNext;
  logic [AW:0]   cnt;
  logic [1:0]    issueClamp;
  logic [1:0]    enq;
  logic [1:0]    deq;
  logic          accept;

  assign count      = cnt;
  assign headNext   = head + AW'(1);
  assign tailNext   = tail + AW'(1);
  assign in_ready   = (cnt <= READY_MAX);
  assign accept     = in_valid & in_ready;
  assign out_valid0 = (cnt != '0);
  assign out_valid1 = (cnt > (AW+1)'(1));
  assign out_inst0  = mem[head];
  assign out_inst1  = mem[headNext];

  always_comb begin
    issueClamp = (issue == 2'd3) ? 2'd2 : issue;
    enq        = 2'd0;
    if (accept) enq = in_skip0 ? 2'd1 : 2'd2;
    // Over-issue beyond occupancy is clamped; cnt fits in two bits whenever it is smaller.
    if (cnt >= (AW+1)'(issueClamp)) deq = issueClamp;
    else                            deq = cnt[1:0];
  end

  // Bit 63 is big-endian bit 0, so the older instruction lives in in_data[63:32].
  always_ff @(posedge clk) begin
    if (!flush && accept) begin
      if (in_skip0) begin
        mem[tail] <= in_data[31:0];
      end else begin
        mem[tail]     <= in_data[63:32];
        mem[tailNext] <= in_data[31:0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      head <= head + AW'(deq);
      tail <= tail + AW'(enq);
      cnt  <= cnt + (AW+1)'(enq) - (AW+1)'(deq);
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: the driver queues expected instructions on
// accepted words, a negedge monitor pops and compares as decode consumes them.
module tb_fetch_queue;
  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          in_skip0;
  logic [63:0]   in_data;
  logic          in_ready;
  logic          out_valid0;
  logic [31:0]   out_inst0;
  logic          out_valid1;
  logic [31:0]   out_inst1;
  logic [1:0]    issue;
  logic [AW:0]   count;

  int nChecks = 0;
  int nFails  = 0;
  logic [31:0] sbq[$];

  fetch_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid),
    .in_skip0(in_skip0), .in_data(in_data), .in_ready(in_ready),
    .out_valid0(out_valid0), .out_inst0(out_inst0), .out_valid1(out_valid1),
    .out_inst1(out_inst1), .issue(issue), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compares every instruction decode actually consumes this cycle.
  always @(negedge clk) begin
    if (!reset && !flush) begin
      if (issue != 2'd0 && out_valid0) begin
        if (sbq.size() == 0) check("sb_empty0", 64'd1, 64'd0);
        else                 check("inst0", {32'd0, out_inst0}, {32'd0, sbq.pop_front()});
      end
      if (issue >= 2'd2 && out_valid1) begin
        if (sbq.size() == 0) check("sb_empty1", 64'd1, 64'd0);
        else                 check("inst1", {32'd0, out_inst1}, {32'd0, sbq.pop_front()});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0; in_skip0 = 1'b0; in_data = '0; issue = 2'd0; flush = 1'b0;
  endtask

  task automatic drive(input logic v, input logic s, input logic [63:0] d,
                       input logic [1:0] iss, input logic expAccept);
    in_valid = v; in_skip0 = s; in_data = d; issue = iss;
    if (v) begin
      check("in_ready", {63'd0, in_ready}, {63'd0, expAccept});
      if (expAccept) begin
        if (!s) sbq.push_back(d[63:32]);
        sbq.push_back(d[31:0]);
      end
    end
    step();
  endtask

  initial begin
    idle();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    check("rst_count", 64'(count), 64'd0);
    check("rst_valid0", {63'd0, out_valid0}, 64'd0);
    check("rst_valid1", {63'd0, out_valid1}, 64'd0);
    check("rst_ready", {63'd0, in_ready}, 64'd1);

    // Skipped older half into an empty queue
    drive(1'b1, 1'b1, {32'hDEADBEEF, 32'h7C221A14}, 2'd0, 1'b1);
    idle();
    check("skip_count", 64'(count), 64'd1);
    check("skip_inst0", 64'(out_inst0), 64'h7C221A14);
    check("skip_valid1", {63'd0, out_valid1}, 64'd0);

    // Over-issue at count 1 with a simultaneous two-instruction enqueue
    drive(1'b1, 1'b0, {32'h11111111, 32'h22222222}, 2'd2, 1'b1);
    idle();
    check("ovr_count", 64'(count), 64'd2);
    check("ovr_inst0", 64'(out_inst0), 64'h11111111);
    drive(1'b0, 1'b0, 64'd0, 2'd2, 1'b0);
    idle();
    check("ovr_drain", 64'(count), 64'd0);

    // Fill to DEPTH with no issue
    for (int k = 0; k < 32; k++)
      drive(1'b1, 1'b0, {32'h38000000 + 32'(2*k), 32'h38000000 + 32'(2*k+1)}, 2'd0, 1'b1);
    idle();
    check("full_count", 64'(count), 64'd64);
    check("full_ready", {63'd0, in_ready}, 64'd0);
    drive(1'b1, 1'b0, {32'hBAD0BAD0, 32'hBAD1BAD1}, 2'd0, 1'b0);
    idle();
    check("full_hold_count", 64'(count), 64'd64);
    check("full_inst0", 64'(out_inst0), 64'h38000000);
    check("full_inst1", 64'(out_inst1), 64'h38000001);

    // Drain; issue = 3 must behave as 2
    drive(1'b0, 1'b0, 64'd0, 2'd3, 1'b0);
    idle();
    check("issue3_count", 64'(count), 64'd62);
    for (int k = 0; k < 31; k++) drive(1'b0, 1'b0, 64'd0, 2'd2, 1'b0);
    idle();
    check("drain_count", 64'(count), 64'd0);
    drive(1'b0, 1'b0, 64'd0, 2'd2, 1'b0);
    idle();
    check("empty_issue", 64'(count), 64'd0);
    check("empty_ready", {63'd0, in_ready}, 64'd1);

    // Steady state 2 in / 2 out across several wraps
    for (int k = 0; k < 100; k++) begin
      drive(1'b1, 1'b0, {32'h50000000 + 32'(2*k), 32'h50000000 + 32'(2*k+1)}, 2'd2, 1'b1);
      check("steady_count", 64'(count), 64'd2);
    end
    drive(1'b0, 1'b0, 64'd0, 2'd2, 1'b0);
    idle();
    check("steady_drain", 64'(count), 64'd0);
    check("steady_sb", 64'(sbq.size()), 64'd0);

    // Flush beats enqueue and dequeue in the same cycle
    for (int k = 0; k < 10; k++)
      drive(1'b1, 1'b0, {32'h60000000 + 32'(2*k), 32'h60000000 + 32'(2*k+1)}, 2'd0, 1'b1);
    idle();
    check("preflush_count", 64'(count), 64'd20);
    flush = 1'b1; in_valid = 1'b1; in_data = {32'hAAAAAAAA, 32'hBBBBBBBB}; issue = 2'd2;
    sbq.delete();
    step();
    idle();
    check("flush_count", 64'(count), 64'd0);
    check("flush_head", 64'(dut.head), 64'd0);
    check("flush_tail", 64'(dut.tail), 64'd0);
    check("flush_ready", {63'd0, in_ready}, 64'd1);
    check("flush_valid0", {63'd0, out_valid0}, 64'd0);
    drive(1'b1, 1'b0, {32'h12345678, 32'h9ABCDEF0}, 2'd0, 1'b1);
    idle();
    check("postflush_count", 64'(count), 64'd2);
    check("postflush_inst0", 64'(out_inst0), 64'h12345678);
    check("postflush_inst1", 64'(out_inst1), 64'h9ABCDEF0);
    drive(1'b0, 1'b0, 64'd0, 2'd2, 1'b0);
    idle();

    // Asynchronous reset between edges at count = 10
    for (int k = 0; k < 5; k++)
      drive(1'b1, 1'b0, {32'h70000000 + 32'(2*k), 32'h70000000 + 32'(2*k+1)}, 2'd0, 1'b1);
    idle();
    check("prereset_count", 64'(count), 64'd10);
    #2;
    reset = 1'b1;
    sbq.delete();
    #1;
    check("arst_count", 64'(count), 64'd0);
    check("arst_valid0", {63'd0, out_valid0}, 64'd0);
    check("arst_ready", {63'd0, in_ready}, 64'd1);
    step();
    reset = 1'b0;
    step();
    check("postrst_count", 64'(count), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
